// File: rtl/bin_loader.sv
// bin_loader: streams one bin into a sat_engine, runs it, writes results back to memory.
// Define BIN_LOADER_PERF_CNT_EN to add the run_cycles_o RUN-cycle counter.
module bin_loader #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_ADDR       = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) (
`ifdef BIN_LOADER_PERF_CNT_EN
    output logic [31:0]                          run_cycles_o,
`endif
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [WIDTH_BIN_ID-1:0]              bin_id_i,
    input  logic [WIDTH_LVL-1:0]                 load_lvl_i,
    input  logic [WIDTH_LVL-1:0]                 base_lvl_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 sat_o,
    output logic                                 unsat_o,
    output logic [WIDTH_LVL-1:0]                 cur_lvl_o,
    output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0]              bkt_bin_o,
    output logic                                 mem_rd_o,
    output logic                                 mem_wr_o,
    output logic [WIDTH_ADDR-1:0]                mem_addr_o,
    input  logic [2*NUM_VARS-1:0]                mem_rdata_i,
    output logic [2*NUM_VARS-1:0]                mem_wdata_o,
    output logic                                 st_rd_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] st_vars_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] st_lvls_i,
    output logic                                 st_wr_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] st_vars_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] st_lvls_o,
    output logic                                 start_core_o,
    input  logic                                 done_core_i,
    input  logic                                 core_sat_i,
    input  logic                                 core_unsat_i,
    input  logic [WIDTH_LVL-1:0]                 core_cur_lvl_i,
    input  logic [WIDTH_LVL-1:0]                 core_bkt_lvl_i,
    input  logic [WIDTH_BIN_ID-1:0]              core_bkt_bin_i,
    output logic [WIDTH_LVL-1:0]                 cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                 load_lvl_o,
    output logic                                 base_lvl_en_o,
    output logic [WIDTH_LVL-1:0]                 base_lvl_o,
    output logic [NUM_CLAUSES-1:0]               wr_carray_o,
    output logic [NUM_CLAUSES-1:0]               rd_carray_o,
    output logic [2*NUM_VARS-1:0]                clause_o,
    input  logic [2*NUM_VARS-1:0]                clause_i,
    output logic [NUM_VARS-1:0]                  wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
    output logic [NUM_LVLS-1:0]                  wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i
);
    localparam int IW = $clog2(NUM_CLAUSES) + 1;
    localparam logic [2:0] S_IDLE  = 3'd0, S_LD_CL = 3'd1, S_LD_ST = 3'd2, S_START = 3'd3,
                           S_RUN   = 3'd4, S_WB_CL = 3'd5, S_WB_ST = 3'd6, S_DONE  = 3'd7;

    logic [2:0]              state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [WIDTH_BIN_ID-1:0] bin_id_q, bin_id_d, bkt_bin_q, bkt_bin_d;
    logic [WIDTH_LVL-1:0]    load_lvl_q, load_lvl_d, base_lvl_q, base_lvl_d;
    logic [WIDTH_LVL-1:0]    cur_lvl_q, cur_lvl_d, bkt_lvl_q, bkt_lvl_d;
    logic                    sat_q, sat_d, unsat_q, unsat_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        bin_id_d   = bin_id_q;
        load_lvl_d = load_lvl_q;
        base_lvl_d = base_lvl_q;
        sat_d      = sat_q;
        unsat_d    = unsat_q;
        cur_lvl_d  = cur_lvl_q;
        bkt_lvl_d  = bkt_lvl_q;
        bkt_bin_d  = bkt_bin_q;
        case (state_q)
            S_IDLE: if (start_i) begin
                state_d    = S_LD_CL;
                idx_d      = '0;
                bin_id_d   = bin_id_i;
                load_lvl_d = load_lvl_i;
                base_lvl_d = base_lvl_i;
                sat_d      = 1'b0;
                unsat_d    = 1'b0;
                cur_lvl_d  = '0;
                bkt_lvl_d  = '0;
                bkt_bin_d  = '0;
            end
            S_LD_CL, S_WB_CL: begin
                idx_d = idx_q + IW'(1);
                if (idx_q == IW'(NUM_CLAUSES)) begin
                    state_d = (state_q == S_LD_CL) ? S_LD_ST : S_WB_ST;
                    idx_d   = '0;
                end
            end
            S_LD_ST: begin
                idx_d = idx_q + IW'(1);
                if (idx_q != '0) begin
                    state_d = S_START;
                    idx_d   = '0;
                end
            end
            S_START: state_d = S_RUN;
            S_RUN: if (done_core_i) begin
                state_d   = S_WB_CL;
                idx_d     = '0;
                sat_d     = core_sat_i;
                unsat_d   = core_unsat_i;
                cur_lvl_d = core_cur_lvl_i;
                bkt_lvl_d = core_bkt_lvl_i;
                bkt_bin_d = core_bkt_bin_i;
            end
            S_WB_ST: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            bin_id_q   <= '0;
            load_lvl_q <= '0;
            base_lvl_q <= '0;
            sat_q      <= 1'b0;
            unsat_q    <= 1'b0;
            cur_lvl_q  <= '0;
            bkt_lvl_q  <= '0;
            bkt_bin_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            bin_id_q   <= bin_id_d;
            load_lvl_q <= load_lvl_d;
            base_lvl_q <= base_lvl_d;
            sat_q      <= sat_d;
            unsat_q    <= unsat_d;
            cur_lvl_q  <= cur_lvl_d;
            bkt_lvl_q  <= bkt_lvl_d;
            bkt_bin_q  <= bkt_bin_d;
        end
    end

    // Clause streams are pipelined: issue slot idx, data for slot idx-1 returns in the same cycle.
    logic          ld_cl, wb_cl, issue, ret, st_ld;
    logic [IW-1:0] addr_idx;
    assign ld_cl    = state_q == S_LD_CL;
    assign wb_cl    = state_q == S_WB_CL;
    assign issue    = idx_q < IW'(NUM_CLAUSES);
    assign ret      = idx_q != '0;
    assign st_ld    = state_q == S_LD_ST && idx_q != '0;
    assign addr_idx = ld_cl ? idx_q : idx_q - IW'(1);

    assign mem_rd_o    = ld_cl && issue;
    assign mem_wr_o    = wb_cl && ret;
    assign mem_addr_o  = (mem_rd_o || mem_wr_o) ?
                         WIDTH_ADDR'(32'(bin_id_q) * 32'(NUM_CLAUSES) + 32'(addr_idx)) : '0;
    assign mem_wdata_o = mem_wr_o ? clause_i : '0;
    assign wr_carray_o = (ld_cl && ret) ? NUM_CLAUSES'(1) << (idx_q - IW'(1)) : '0;
    assign rd_carray_o = (wb_cl && issue) ? NUM_CLAUSES'(1) << idx_q : '0;
    assign clause_o    = (ld_cl && ret) ? mem_rdata_i : '0;

    assign st_rd_o         = state_q == S_LD_ST && idx_q == '0;
    assign wr_var_states_o = st_ld ? '1 : '0;
    assign wr_lvl_states_o = st_ld ? '1 : '0;
    assign vars_states_o   = st_ld ? st_vars_i : '0;
    assign lvl_states_o    = st_ld ? st_lvls_i : '0;
    assign base_lvl_en_o   = st_ld;
    assign base_lvl_o      = st_ld ? base_lvl_q : '0;

    assign st_wr_o   = state_q == S_WB_ST;
    assign st_vars_o = st_wr_o ? vars_states_i : '0;
    assign st_lvls_o = st_wr_o ? lvl_states_i : '0;

    assign start_core_o  = state_q == S_START;
    assign cur_bin_num_o = WIDTH_LVL'(bin_id_q);
    assign load_lvl_o    = load_lvl_q;
    assign busy_o        = state_q != S_IDLE && state_q != S_DONE;
    assign done_o        = state_q == S_DONE;
    assign sat_o         = sat_q;
    assign unsat_o       = unsat_q;
    assign cur_lvl_o     = cur_lvl_q;
    assign bkt_lvl_o     = bkt_lvl_q;
    assign bkt_bin_o     = bkt_bin_q;

`ifdef BIN_LOADER_PERF_CNT_EN
    logic [31:0] run_cnt_q, run_cnt_d;
    always_comb run_cnt_d = (state_q == S_IDLE && start_i) ? '0 :
                            (state_q == S_RUN && run_cnt_q != '1) ? run_cnt_q + 32'd1 : run_cnt_q;
    always_ff @(posedge clk) run_cnt_q <= !rst ? '0 : run_cnt_d;
    assign run_cycles_o = run_cnt_q;
`endif
endmodule

// File: tb/tb_bin_loader.sv
// tb_bin_loader: directed checks of bin_loader with a clause-memory model and a small engine model.
module tb_bin_loader;
    logic          clk = 1'b0, rst = 1'b0, start_i = 1'b0;
    logic [9:0]    bin_id_i = '0;
    logic [15:0]   load_lvl_i = '0, base_lvl_i = '0;
    logic          busy_o, done_o, sat_o, unsat_o;
    logic [15:0]   cur_lvl_o, bkt_lvl_o;
    logic [9:0]    bkt_bin_o;
    logic          mem_rd_o, mem_wr_o, st_rd_o, st_wr_o, start_core_o, base_lvl_en_o;
    logic [15:0]   mem_addr_o, mem_rdata_i = '0, mem_wdata_o;
    logic [151:0]  st_vars_i, st_vars_o, vars_states_o, vars_states_i;
    logic [87:0]   st_lvls_i, st_lvls_o, lvl_states_o, lvl_states_i;
    logic          done_core_i = 1'b0, core_sat_i = 1'b0, core_unsat_i = 1'b0;
    logic [15:0]   core_cur_lvl_i = '0, core_bkt_lvl_i = '0;
    logic [9:0]    core_bkt_bin_i = '0;
    logic [15:0]   cur_bin_num_o, load_lvl_o, base_lvl_o;
    logic [7:0]    wr_carray_o, rd_carray_o, wr_var_states_o, wr_lvl_states_o;
    logic [15:0]   clause_o, clause_i = '0;
`ifdef BIN_LOADER_PERF_CNT_EN
    logic [31:0]   run_cycles_o;
`endif

    bin_loader dut (
`ifdef BIN_LOADER_PERF_CNT_EN
        .run_cycles_o(run_cycles_o),
`endif
        .clk(clk), .rst(rst), .start_i(start_i), .bin_id_i(bin_id_i), .load_lvl_i(load_lvl_i),
        .base_lvl_i(base_lvl_i), .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o), .unsat_o(unsat_o),
        .cur_lvl_o(cur_lvl_o), .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o), .mem_rd_o(mem_rd_o),
        .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .mem_wdata_o(mem_wdata_o),
        .st_rd_o(st_rd_o), .st_vars_i(st_vars_i), .st_lvls_i(st_lvls_i), .st_wr_o(st_wr_o),
        .st_vars_o(st_vars_o), .st_lvls_o(st_lvls_o), .start_core_o(start_core_o), .done_core_i(done_core_i),
        .core_sat_i(core_sat_i), .core_unsat_i(core_unsat_i), .core_cur_lvl_i(core_cur_lvl_i),
        .core_bkt_lvl_i(core_bkt_lvl_i), .core_bkt_bin_i(core_bkt_bin_i), .cur_bin_num_o(cur_bin_num_o),
        .load_lvl_o(load_lvl_o), .base_lvl_en_o(base_lvl_en_o), .base_lvl_o(base_lvl_o),
        .wr_carray_o(wr_carray_o), .rd_carray_o(rd_carray_o), .clause_o(clause_o), .clause_i(clause_i),
        .wr_var_states_o(wr_var_states_o), .vars_states_o(vars_states_o), .vars_states_i(vars_states_i),
        .wr_lvl_states_o(wr_lvl_states_o), .lvl_states_o(lvl_states_o), .lvl_states_i(lvl_states_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Clause memory returns 16'hC000|addr one cycle after a read.
    always @(posedge clk) if (mem_rd_o) mem_rdata_i <= 16'hC000 | mem_addr_o;

    // Engine clause array; slot 2 can be overridden to emulate an updated clause.
    logic [15:0] eng [8];
    logic        ovr_en = 1'b0;
    always @(posedge clk)
        for (int k = 0; k < 8; k++) begin
            if (wr_carray_o[k]) eng[k] <= clause_o;
            if (rd_carray_o[k]) clause_i <= (ovr_en && k == 2) ? 16'hA5A5 : eng[k];
        end

    int          rd_n = 0, wc_n = 0, wr_n = 0, done_n = 0, viol = 0;
    logic [15:0] rd_addr [64], wc_data [64], wr_addr [64], wr_data [64];
    logic [7:0]  wc_oh [64];
    logic [151:0] ld_vars = '0, sw_vars = '0;
    logic [87:0]  ld_lvls = '0, sw_lvls = '0;
    logic [15:0]  ld_base = '0;
    always @(negedge clk) begin
        if (mem_rd_o && rd_n < 64) begin rd_addr[rd_n] = mem_addr_o; rd_n++; end
        if (wr_carray_o != '0 && wc_n < 64) begin wc_oh[wc_n] = wr_carray_o; wc_data[wc_n] = clause_o; wc_n++; end
        if (mem_wr_o && wr_n < 64) begin wr_addr[wr_n] = mem_addr_o; wr_data[wr_n] = mem_wdata_o; wr_n++; end
        if (wr_var_states_o != '0) begin ld_vars = vars_states_o; ld_lvls = lvl_states_o; end
        if (base_lvl_en_o) ld_base = base_lvl_o;
        if (st_wr_o) begin sw_vars = st_vars_o; sw_lvls = st_lvls_o; end
        if (done_o) done_n++;
        if ($countones(wr_carray_o) > 1 || $countones(rd_carray_o) > 1 ||
            (wr_carray_o != '0 && rd_carray_o != '0) || (mem_rd_o && mem_wr_o)) viol++;
    end

    int tests = 0, fails = 0;
    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_run(input logic [9:0] bin, input logic [15:0] ll, input logic [15:0] bl,
                          input int run_len, output int lat);
        int c0;
        @(posedge clk); #1;
        bin_id_i = bin; load_lvl_i = ll; base_lvl_i = bl; start_i = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 100 && !start_core_o; i++) begin @(posedge clk); #1; end
        chk("start_core", start_core_o, 1);
        chk("load_lvl", load_lvl_o, ll);
        chk("cur_bin", cur_bin_num_o, 16'(bin));
        done_core_i = 1'b1;
        for (int j = 1; j <= run_len; j++) begin
            @(posedge clk); #1;
            done_core_i = (j == run_len);
            start_i     = (j == 1 && run_len > 1);
            bin_id_i    = 10'd9;
        end
        @(posedge clk); #1;
        done_core_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 100 && !done_o; i++) begin @(posedge clk); #1; end
        chk("done_seen", done_o, 1);
        lat = cyc - c0 + 1;
    endtask

    int lat, rd0, wc0, wr0, d0;
    initial begin
        st_vars_i = {8{19'h5A5A5}}; st_lvls_i = {8{11'h3C3}};
        vars_states_i = {8{19'h12345}}; lvl_states_i = {8{11'h2AA}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_strobes", {busy_o, done_o, mem_rd_o, mem_wr_o, st_rd_o, st_wr_o, start_core_o,
                            base_lvl_en_o, sat_o, unsat_o, wr_carray_o, rd_carray_o}, 0);
        chk("rst_data", {mem_addr_o, cur_lvl_o, bkt_lvl_o, bkt_bin_o, cur_bin_num_o, load_lvl_o}, 0);
        rst = 1'b1;

        // Abort a load with a mid-flight reset.
        @(posedge clk); #1;
        bin_id_i = 10'd5; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        chk("midld_busy", {busy_o, mem_rd_o}, 2'b11);
        chk("midld_addr", mem_addr_o, 41);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_strobes", {busy_o, done_o, mem_rd_o, mem_wr_o, st_rd_o, st_wr_o, start_core_o,
                              wr_carray_o, rd_carray_o}, 0);
        chk("abort_data", {mem_addr_o, clause_o, cur_bin_num_o}, 0);
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_wr", wr_n, 0);
        chk("abort_no_done", {done_n, 31'(busy_o)}, 0);

        // Main run: bin 3, unsat result, slot 2 updated by the engine.
        core_unsat_i = 1'b1; core_sat_i = 1'b0; core_cur_lvl_i = 16'd6; core_bkt_lvl_i = 16'd2;
        core_bkt_bin_i = 10'd1; ovr_en = 1'b1;
        rd0 = rd_n; wc0 = wc_n; wr0 = wr_n; d0 = done_n;
        do_run(10'd3, 16'd7, 16'd4, 5, lat);
        chk("latency_5", lat, 29);
        chk("res_unsat", {sat_o, unsat_o}, 2'b01);
        chk("res_lvls", {cur_lvl_o, bkt_lvl_o, bkt_bin_o}, {16'd6, 16'd2, 10'd1});
`ifdef BIN_LOADER_PERF_CNT_EN
        chk("run_cycles", run_cycles_o, 5);
`endif
        @(negedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rd_addr%0d", k), rd_addr[rd0+k], 24 + k);
            chk($sformatf("wc_oh%0d", k), wc_oh[wc0+k], 8'd1 << k);
            chk($sformatf("wc_data%0d", k), wc_data[wc0+k], 16'hC018 + 16'(k));
        end
        chk("ld_vars", ld_vars, {8{19'h5A5A5}});
        chk("ld_lvls", ld_lvls, {8{11'h3C3}});
        chk("ld_base", ld_base, 4);
        chk("wr_count", wr_n - wr0, 8);
        chk("wb_slot2", {wr_addr[wr0+2], wr_data[wr0+2]}, {16'd26, 16'hA5A5});
        chk("wb_slot5", {wr_addr[wr0+5], wr_data[wr0+5]}, {16'd29, 16'hC01D});
        chk("st_wr_vars", sw_vars, {8{19'h12345}});
        chk("st_wr_lvls", sw_lvls, {8{11'h2AA}});
        repeat (10) @(posedge clk);
        #1;
        chk("hold_res", {unsat_o, bkt_lvl_o, bkt_bin_o}, {1'b1, 16'd2, 10'd1});
        chk("single_done", done_n - d0, 1);
        chk("single_load", rd_n - rd0, 8);
        chk("idle_busy", busy_o, 0);

        // Second run: bin 0, sat after a one-cycle RUN.
        core_unsat_i = 1'b0; core_sat_i = 1'b1; core_bkt_lvl_i = 16'd0; core_bkt_bin_i = 10'd0;
        ovr_en = 1'b0; rd0 = rd_n;
        do_run(10'd0, 16'd1, 16'd0, 1, lat);
        chk("latency_1", lat, 25);
        chk("res_sat", {sat_o, unsat_o, bkt_lvl_o}, {2'b10, 16'd0});
`ifdef BIN_LOADER_PERF_CNT_EN
        chk("run_cycles_1", run_cycles_o, 1);
`endif
        @(negedge clk); #1;
        chk("bin0_addr0", rd_addr[rd0], 0);
        chk("bin0_addr7", rd_addr[rd0+7], 7);
        chk("onehot_excl", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
